// File: rtl/musa_pkg.sv
// Shared definitions for the MUSA core front end: word width, reset fetch
// address and the instruction-fetch state encoding.
package musa_pkg;

  localparam int unsigned WORD_W = 32;
  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/return_stack.sv
// Circular return-address stack with saturating occupancy and sticky
// overflow/underflow flags; the top entry is held in a register.
module return_stack
  import musa_pkg::*;
#(
  parameter int unsigned STACK_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [WORD_W-1:0] push_addr,
  input  logic              pop,
  output logic [WORD_W-1:0] top,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned PTR_W = $clog2(STACK_DEPTH);
  localparam int unsigned CNT_W = $clog2(STACK_DEPTH + 1);

  logic [WORD_W-1:0] mem [STACK_DEPTH];
  logic [PTR_W-1:0]  top_ptr_reg;
  logic [PTR_W-1:0]  ptr_up;
  logic [PTR_W-1:0]  ptr_dn;
  logic [CNT_W-1:0]  count_reg;
  logic [WORD_W-1:0] top_reg;
  logic              overflow_reg;
  logic              underflow_reg;
  logic              empty;
  logic              full;
  logic              do_push;
  logic              do_replace;
  logic              do_pop;

  assign ptr_up     = top_ptr_reg + PTR_W'(1);
  assign ptr_dn     = top_ptr_reg - PTR_W'(1);
  assign empty      = (count_reg == '0);
  assign full       = (count_reg == CNT_W'(STACK_DEPTH));
  // A simultaneous push/pop on an empty stack degenerates to a plain push.
  assign do_push    = push && (!pop || empty);
  assign do_replace = push && pop && !empty;
  assign do_pop     = pop && !push && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[ptr_up] <= push_addr;
    end else if (do_replace) begin
      mem[top_ptr_reg] <= push_addr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      top_ptr_reg   <= '0;
      count_reg     <= '0;
      top_reg       <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (do_push) begin
        top_ptr_reg <= ptr_up;
        top_reg     <= push_addr;
        if (full) begin
          overflow_reg <= 1'b1;
        end else begin
          count_reg <= count_reg + CNT_W'(1);
        end
      end else if (do_replace) begin
        top_reg <= push_addr;
      end else if (do_pop) begin
        top_ptr_reg <= ptr_dn;
        count_reg   <= count_reg - CNT_W'(1);
        top_reg     <= (count_reg == CNT_W'(1)) ? '0 : mem[ptr_dn];
      end else if (pop && !push) begin
        underflow_reg <= 1'b1;
      end
    end
  end

  assign top       = top_reg;
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

endmodule

// File: rtl/if_stage.sv
// MUSA instruction-fetch stage: program counter, memory request handshake,
// one-entry skid buffer, redirect drain and the return-address stack.
module if_stage
  import musa_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int unsigned       STACK_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] next_pc,
  input  logic              redirect,
  input  logic              stall,
  input  logic              push,
  input  logic [WORD_W-1:0] push_addr,
  input  logic              pop,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [WORD_W-1:0] imem_data,
  output logic [WORD_W-1:0] instr,
  output logic              instr_valid,
  output logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] pc_1,
  output logic [WORD_W-1:0] stack,
  output logic              stack_overflow,
  output logic              stack_underflow
);

  fetch_state_e      state_reg;
  logic [WORD_W-1:0] fetch_pc_reg;
  logic [WORD_W-1:0] fetch_pc_next;
  logic              imem_req_reg;
  logic [WORD_W-1:0] imem_addr_reg;
  logic [WORD_W-1:0] instr_reg;
  logic              instr_valid_reg;
  logic [WORD_W-1:0] pc_reg;
  logic [WORD_W-1:0] pc_1_reg;
  logic              skid_valid_reg;
  logic              skid_valid_next;
  logic [WORD_W-1:0] skid_instr_reg;
  logic [WORD_W-1:0] skid_pc_reg;
  logic              ack_v;
  logic              req_hold;
  logic              out_free;
  logic              fetch_ack;

  assign ack_v     = imem_req_reg && imem_ack;
  assign req_hold  = imem_req_reg && !imem_ack;
  assign out_free  = !instr_valid_reg || !stall;
  // Only an ack in FETCH without a concurrent redirect carries a usable word.
  assign fetch_ack = (state_reg == FETCH) && ack_v && !redirect;

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    if (redirect) begin
      fetch_pc_next = next_pc;
    end else if (fetch_ack) begin
      fetch_pc_next = fetch_pc_reg + 32'd1;
    end

    skid_valid_next = skid_valid_reg;
    if (redirect) begin
      skid_valid_next = 1'b0;
    end else if (out_free) begin
      skid_valid_next = skid_valid_reg && fetch_ack;
    end else if (fetch_ack) begin
      skid_valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= FETCH;
      fetch_pc_reg    <= RESET_PC;
      imem_req_reg    <= 1'b0;
      imem_addr_reg   <= RESET_PC;
      instr_reg       <= '0;
      instr_valid_reg <= 1'b0;
      pc_reg          <= RESET_PC;
      pc_1_reg        <= RESET_PC + 32'd1;
      skid_valid_reg  <= 1'b0;
      skid_instr_reg  <= '0;
      skid_pc_reg     <= '0;
    end else begin
      fetch_pc_reg   <= fetch_pc_next;
      skid_valid_reg <= skid_valid_next;

      case (state_reg)
        FETCH: if (redirect && req_hold) state_reg <= DRAIN;
        DRAIN: if (ack_v) state_reg <= FETCH;
        default: state_reg <= FETCH;
      endcase

      // An unanswered request is frozen; otherwise issue from the fetch PC.
      if (!req_hold) begin
        imem_req_reg  <= !skid_valid_next;
        imem_addr_reg <= fetch_pc_next;
      end

      if (redirect) begin
        instr_valid_reg <= 1'b0;
      end else if (out_free) begin
        if (skid_valid_reg) begin
          instr_reg       <= skid_instr_reg;
          pc_reg          <= skid_pc_reg;
          pc_1_reg        <= skid_pc_reg + 32'd1;
          instr_valid_reg <= 1'b1;
        end else if (fetch_ack) begin
          instr_reg       <= imem_data;
          pc_reg          <= imem_addr_reg;
          pc_1_reg        <= imem_addr_reg + 32'd1;
          instr_valid_reg <= 1'b1;
        end else begin
          instr_valid_reg <= 1'b0;
        end
      end

      if (fetch_ack && (!out_free || skid_valid_reg)) begin
        skid_instr_reg <= imem_data;
        skid_pc_reg    <= imem_addr_reg;
      end
    end
  end

  return_stack #(
    .STACK_DEPTH(STACK_DEPTH)
  ) u_return_stack (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_addr(push_addr),
    .pop      (pop),
    .top      (stack),
    .overflow (stack_overflow),
    .underflow(stack_underflow)
  );

  assign imem_req    = imem_req_reg;
  assign imem_addr   = imem_addr_reg;
  assign instr       = instr_reg;
  assign instr_valid = instr_valid_reg;
  assign pc          = pc_reg;
  assign pc_1        = pc_1_reg;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: per-cycle fetch vectors, return-stack vectors
// and hand sequences for reset behaviour.
module tb_if_stage;

  localparam logic [31:0] KEY = 32'hA5A5_0000;
  localparam int NF = 21;
  localparam int NS = 25;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] next_pc = '0;
  logic        redirect = 1'b0;
  logic        stall = 1'b0;
  logic        push = 1'b0;
  logic [31:0] push_addr = '0;
  logic        pop = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_1;
  logic [31:0] stack;
  logic        stack_overflow;
  logic        stack_underflow;
  logic        ack_en = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        stall;
    logic        ack;
    logic        redir;
    logic [31:0] npc;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
  } fvec_t;

  typedef struct {
    logic        push;
    logic        pop;
    logic [31:0] addr;
    logic [31:0] top;
    logic        ovf;
    logic        unf;
  } svec_t;

  fvec_t fv[NF];
  svec_t sv[NS];

  if_stage #(
    .RESET_PC   (32'h0000_0000),
    .STACK_DEPTH(8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .next_pc        (next_pc),
    .redirect       (redirect),
    .stall          (stall),
    .push           (push),
    .push_addr      (push_addr),
    .pop            (pop),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_data      (imem_data),
    .instr          (instr),
    .instr_valid    (instr_valid),
    .pc             (pc),
    .pc_1           (pc_1),
    .stack          (stack),
    .stack_overflow (stack_overflow),
    .stack_underflow(stack_underflow)
  );

  always #5 clk = ~clk;

  // Memory model: combinational ack, word content derived from its address.
  assign imem_ack  = imem_req & ack_en;
  assign imem_data = imem_addr ^ KEY;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic fvec_t fmk(input logic s, input logic a, input logic r, input logic [31:0] n,
                                input logic q, input logic [31:0] ad, input logic v, input logic [31:0] p);
    fvec_t t;
    t.stall = s; t.ack = a; t.redir = r; t.npc = n;
    t.req = q; t.addr = ad; t.valid = v; t.pc = p;
    return t;
  endfunction

  function automatic svec_t smk(input logic pu, input logic po, input logic [31:0] ad,
                                input logic [31:0] tp, input logic ov, input logic un);
    svec_t t;
    t.push = pu; t.pop = po; t.addr = ad; t.top = tp; t.ovf = ov; t.unf = un;
    return t;
  endfunction

  initial begin
    // stall, ack, redirect, next_pc -> req, addr, valid, pc
    fv[0]  = fmk(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0,         1'b0, 32'h0);
    fv[1]  = fmk(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h1,         1'b1, 32'h0);
    fv[2]  = fmk(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h2,         1'b1, 32'h1);
    fv[3]  = fmk(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h3,         1'b1, 32'h2);
    fv[4]  = fmk(1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h4,         1'b1, 32'h2);
    fv[5]  = fmk(1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h4,         1'b1, 32'h2);
    fv[6]  = fmk(1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h4,         1'b1, 32'h2);
    fv[7]  = fmk(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h4,         1'b1, 32'h3);
    fv[8]  = fmk(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h5,         1'b1, 32'h4);
    fv[9]  = fmk(1'b0, 1'b0, 1'b1, 32'h40,        1'b1, 32'h5,         1'b0, 32'h4);
    fv[10] = fmk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h5,         1'b0, 32'h4);
    fv[11] = fmk(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h40,        1'b0, 32'h4);
    fv[12] = fmk(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h41,        1'b1, 32'h40);
    fv[13] = fmk(1'b0, 1'b1, 1'b1, 32'h80,        1'b1, 32'h80,        1'b0, 32'h40);
    fv[14] = fmk(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h81,        1'b1, 32'h80);
    fv[15] = fmk(1'b0, 1'b0, 1'b1, 32'h100,       1'b1, 32'h81,        1'b0, 32'h80);
    fv[16] = fmk(1'b0, 1'b0, 1'b1, 32'h200,       1'b1, 32'h81,        1'b0, 32'h80);
    fv[17] = fmk(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h200,       1'b0, 32'h80);
    fv[18] = fmk(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h201,       1'b1, 32'h200);
    fv[19] = fmk(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h200);
    fv[20] = fmk(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0,         1'b1, 32'hFFFF_FFFF);

    // push, pop, push_addr -> stack, overflow, underflow
    for (int i = 0; i < 9; i++) begin
      sv[i] = smk(1'b1, 1'b0, 32'h101 + 32'(i), 32'h101 + 32'(i), (i == 8), 1'b0);
    end
    for (int k = 1; k <= 8; k++) begin
      sv[8 + k] = smk(1'b0, 1'b1, 32'h0, (k == 8) ? 32'h0 : (32'h109 - 32'(k)), 1'b1, 1'b0);
    end
    sv[17] = smk(1'b0, 1'b1, 32'h0,  32'h0,  1'b1, 1'b1);
    sv[18] = smk(1'b1, 1'b0, 32'h30, 32'h30, 1'b1, 1'b1);
    sv[19] = smk(1'b1, 1'b0, 32'h20, 32'h20, 1'b1, 1'b1);
    sv[20] = smk(1'b1, 1'b1, 32'h10, 32'h10, 1'b1, 1'b1);
    sv[21] = smk(1'b0, 1'b1, 32'h0,  32'h30, 1'b1, 1'b1);
    sv[22] = smk(1'b0, 1'b1, 32'h0,  32'h0,  1'b1, 1'b1);
    sv[23] = smk(1'b1, 1'b1, 32'h55, 32'h55, 1'b1, 1'b1);
    sv[24] = smk(1'b0, 1'b1, 32'h0,  32'h0,  1'b1, 1'b1);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check32("rst imem_req", {31'd0, imem_req}, 32'd0);
    check32("rst imem_addr", imem_addr, 32'h0);
    check32("rst instr", instr, 32'h0);
    check32("rst instr_valid", {31'd0, instr_valid}, 32'd0);
    check32("rst pc", pc, 32'h0);
    check32("rst pc_1", pc_1, 32'h1);
    check32("rst stack", stack, 32'h0);
    check32("rst flags", {30'd0, stack_overflow, stack_underflow}, 32'd0);
    $display("reset: req=%b addr=%h valid=%b pc=%h pc_1=%h", imem_req, imem_addr, instr_valid, pc, pc_1);
    reset = 1'b1;

    for (int i = 0; i < NF; i++) begin
      stall    = fv[i].stall;
      ack_en   = fv[i].ack;
      redirect = fv[i].redir;
      next_pc  = fv[i].npc;
      @(posedge clk);
      #1;
      check32($sformatf("f%0d imem_req", i), {31'd0, imem_req}, {31'd0, fv[i].req});
      check32($sformatf("f%0d imem_addr", i), imem_addr, fv[i].addr);
      check32($sformatf("f%0d instr_valid", i), {31'd0, instr_valid}, {31'd0, fv[i].valid});
      check32($sformatf("f%0d pc", i), pc, fv[i].pc);
      check32($sformatf("f%0d pc_1", i), pc_1, fv[i].pc + 32'd1);
      if (fv[i].valid) begin
        check32($sformatf("f%0d instr", i), instr, fv[i].pc ^ KEY);
      end
      $display("fetch %0d: stall=%b ack=%b redir=%b -> req=%b addr=%h valid=%b pc=%h instr=%h",
               i, fv[i].stall, fv[i].ack, fv[i].redir, imem_req, imem_addr, instr_valid, pc, instr);
    end

    stall    = 1'b0;
    ack_en   = 1'b0;
    redirect = 1'b0;
    for (int i = 0; i < NS; i++) begin
      push      = sv[i].push;
      pop       = sv[i].pop;
      push_addr = sv[i].addr;
      @(posedge clk);
      #1;
      check32($sformatf("s%0d stack", i), stack, sv[i].top);
      check32($sformatf("s%0d overflow", i), {31'd0, stack_overflow}, {31'd0, sv[i].ovf});
      check32($sformatf("s%0d underflow", i), {31'd0, stack_underflow}, {31'd0, sv[i].unf});
      $display("stack %0d: push=%b pop=%b addr=%h -> top=%h ovf=%b unf=%b",
               i, sv[i].push, sv[i].pop, sv[i].addr, stack, stack_overflow, stack_underflow);
    end
    push = 1'b0;
    pop  = 1'b0;

    // Asynchronous reset in mid-cycle while a request is outstanding
    check32("pre-reset imem_req", {31'd0, imem_req}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check32("async imem_req", {31'd0, imem_req}, 32'd0);
    check32("async imem_addr", imem_addr, 32'h0);
    check32("async instr_valid", {31'd0, instr_valid}, 32'd0);
    check32("async pc", pc, 32'h0);
    check32("async stack", stack, 32'h0);
    check32("async flags", {30'd0, stack_overflow, stack_underflow}, 32'd0);
    $display("async reset: req=%b addr=%h valid=%b stack=%h", imem_req, imem_addr, instr_valid, stack);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
